// File: rtl/i2c_line_conditioner.sv
// I2C pad front end: two-flop synchronizers, per-line glitch filters, edge strobes
// and START/STOP detection, all decoded from registered state.

module i2c_lc_channel #(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad_i,
  output logic level_o,
  output logic prev_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          s1_q;
  logic          s2_q;
  logic          f_q;
  logic          f_d;
  logic          p_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Filter: the synchronized level must differ from f for FILTER_CYCLES
  // consecutive cycles; any return to f restarts the count.
  always_comb begin
    f_d   = f_q;
    cnt_d = {CW{1'b0}};
    if (s2_q == f_q) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      f_d   = s2_q;
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Synchronizer, filter and previous-level state; idle-high out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      f_q   <= 1'b1;
      p_q   <= 1'b1;
      cnt_q <= {CW{1'b0}};
    end else begin
      s1_q  <= pad_i;
      s2_q  <= s1_q;
      f_q   <= f_d;
      p_q   <= f_q;
      cnt_q <= cnt_d;
    end
  end

  assign level_o = f_q;
  assign prev_o  = p_q;
  assign rise_o  = f_q & ~p_q;
  assign fall_o  = ~f_q & p_q;

endmodule

module i2c_line_conditioner #(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic SDA_in,
  input  logic SCL_in,
  output logic SDA_sync,
  output logic SCL_sync,
  output logic SDA_rise,
  output logic SDA_fall,
  output logic SCL_rise,
  output logic SCL_fall,
  output logic start_det,
  output logic stop_det
);

  logic sda_prev_s;
  logic scl_prev_s;

  i2c_lc_channel #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda (
    .clk_i   (clk),
    .rst_ni  (n_rst),
    .pad_i   (SDA_in),
    .level_o (SDA_sync),
    .prev_o  (sda_prev_s),
    .rise_o  (SDA_rise),
    .fall_o  (SDA_fall)
  );

  i2c_lc_channel #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl (
    .clk_i   (clk),
    .rst_ni  (n_rst),
    .pad_i   (SCL_in),
    .level_o (SCL_sync),
    .prev_o  (scl_prev_s),
    .rise_o  (SCL_rise),
    .fall_o  (SCL_fall)
  );

  // SCL must be high now and in the previous cycle, so a simultaneous
  // SDA/SCL change never qualifies as START or STOP.
  assign start_det = SDA_fall & SCL_sync & scl_prev_s;
  assign stop_det  = SDA_rise & SCL_sync & scl_prev_s;

  logic unused_s;
  assign unused_s = sda_prev_s;

endmodule

// File: doc/i2c_line_conditioner.md
Name: i2c_line_conditioner

Overview:
- Front end of the I2C master: turns raw, asynchronous SDA/SCL pad inputs into clean, glitch-filtered, clock-domain-synchronous levels (SDA_sync, SCL_sync).
- Also produces single-cycle edge and START/STOP strobes.
- Sits directly upstream of the bus-busy detector and the master controller; its SDA_sync/SCL_sync outputs feed those blocks.

Parameters:
- FILTER_CYCLES, 4, consecutive clk cycles a synchronized line must hold a new level before the filtered output follows. Legal range 1..255.
- Counter width = $clog2(FILTER_CYCLES+1) (localparam, not overridable).

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- SDA_in  input  1  raw SDA pad level, asynchronous
- SCL_in  input  1  raw SCL pad level, asynchronous
- SDA_sync  output  1  synchronized, filtered SDA level
- SCL_sync  output  1  synchronized, filtered SCL level
- SDA_rise  output  1  1-cycle strobe, SDA_sync 0->1
- SDA_fall  output  1  1-cycle strobe, SDA_sync 1->0
- SCL_rise  output  1  1-cycle strobe, SCL_sync 0->1
- SCL_fall  output  1  1-cycle strobe, SCL_sync 1->0
- start_det  output  1  1-cycle strobe, START condition (SDA falls while SCL high)
- stop_det  output  1  1-cycle strobe, STOP condition (SDA rises while SCL high)

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-low on n_rst; all flops clear on the negedge of n_rst.
- Reset values:
  - All synchronizer flops, filtered levels and previous-level registers reset to 1, so the bus reads idle-high.
  - Counters reset to 0.
  - All strobes reset to 0.
  - SDA_sync=1, SCL_sync=1 during and after reset.
- Per line (SDA and SCL are identical, independent channels):
  - 2-flop synchronizer: s1 <= in; s2 <= s1.
  - Filter counter cnt and filtered level f:
    - If s2 == f: cnt <= 0.
    - Else if cnt == FILTER_CYCLES-1: f <= s2; cnt <= 0.
    - Else: cnt <= cnt+1.
  - Any return of s2 to f before the count completes clears cnt. A glitch shorter than FILTER_CYCLES cycles at s2 never reaches f.
  - Latency: a clean pad change set up before clk edge k appears on f after edge k+1+FILTER_CYCLES (FILTER_CYCLES+2 cycles total).
  - Previous-level register: p <= f every cycle.
- Strobes:
  - Decoded only from registers (f, p); no combinational path from SDA_in/SCL_in.
  - rise = f & ~p; fall = ~f & p.
  - Each strobe is high exactly one cycle: the first cycle f shows its new value.
- START/STOP:
  - start_det = SDA_fall & SCL_sync & SCL_p (SCL high and stable in both this and the previous cycle).
  - stop_det = SDA_rise & SCL_sync & SCL_p.
  - If SDA and SCL filtered levels change in the same cycle, neither start_det nor stop_det fires; only the edge strobes do.
- Boundary conditions:
  - start_det and stop_det are mutually exclusive by construction.
  - Reset asserted mid-filter: the count is discarded and outputs return to 1 immediately (asynchronously).
  - Counter never exceeds FILTER_CYCLES-1; no wrap-around.
  - The channels share no state; simultaneous glitches on both lines are filtered independently.

Test Plan:
- Reset with both pads 0 -> SDA_sync=SCL_sync=1 and all strobes 0 while n_rst=0. After release with pads held 0: both outputs fall after 2+4=6 cycles, SDA_fall and SCL_fall each high for exactly 1 cycle, no start_det.
- FILTER_CYCLES=4, both lines idle high; SDA_in pulse low for 3 cycles -> SDA_sync stays 1, no strobes. Pulse low for 4 cycles -> SDA_sync low for exactly 4 cycles; SDA_fall, then SDA_rise, each 1 cycle.
- SCL held 1, SDA_in 1->0 -> SDA_sync falls 6 cycles later; start_det=1 and SDA_fall=1 for that one cycle only.
- SCL held 1, SDA_in 0->1 -> stop_det=1 for 1 cycle, coincident with SDA_rise.
- SDA_in and SCL_in both 1->0 on the same cycle -> both outputs fall on the same cycle; SDA_fall and SCL_fall fire, start_det stays 0.
- n_rst pulsed low 2 cycles into a valid SDA 1->0 filter window -> SDA_sync stays 1. After release, the full 6-cycle latency restarts from scratch.
